uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte-stream requesters. Each requester sends a packet (one or more bytes, last byte flagged); the arbiter locks the grant for the whole packet, then rotates. It sits between the on-chip clients (debug console, status reporter, loopback echo) and the single UART TX serializer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_arb.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (arbiter state, defaults,
//               bit-period shared with serializer and receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        START = 2'd2,
        DRAIN = 2'd3
    } uart_arb_state_t;

    localparam int UART_ARB_NREQ = 4;
    localparam int UART_N        = 5208;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker; searches upward with wrap
//               starting one above i_last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = UART_ARB_NREQ
) (
    input  logic [NREQ-1:0]          i_req,
    input  logic [$clog2(NREQ)-1:0]  i_last_grant,
    output logic [$clog2(NREQ)-1:0]  o_idx,
    output logic                     o_any
);

    localparam int c_W = $clog2(NREQ);

    always_comb begin
        logic [c_W-1:0] w_pos;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = c_W'((int'(i_last_grant) + k) % NREQ);
            if (!o_any && i_req[w_pos]) begin
                o_any = 1'b1;
                o_idx = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin packet arbiter sharing one UART TX serializer
//               among NREQ byte-stream requesters. Optional mid-packet
//               stall abort enabled by UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = UART_ARB_NREQ,
    parameter int TIMEOUT = 104160
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [8*NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     tx_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(NREQ)-1:0]  grant,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int         c_GW    = $clog2(NREQ);
    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_SEND  = SEND;
    localparam logic [1:0] c_START = START;
    localparam logic [1:0] c_DRAIN = DRAIN;

    logic [1:0]       r_state;
    logic [c_GW-1:0]  r_grant;
    logic [c_GW-1:0]  r_last_grant;
    logic             r_busy;
    logic [7:0]       r_tx_data;
    logic             r_last;
    logic [c_GW-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic             w_grant_valid;
    logic             w_abort;
    logic [NREQ-1:0]  w_req_ready;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_idx        (w_pick_idx),
        .o_any        (w_pick_any)
    );

    assign w_grant_valid = req_valid[r_grant];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err_timeout;

    assign w_abort = (r_state == c_SEND) && !w_grant_valid &&
                     (r_to_cnt == c_TO_W'(TIMEOUT - 1));

    // Holding the count at zero outside SEND gives the clear-on-entry behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_abort;
            if (r_state != c_SEND || w_grant_valid) begin
                r_to_cnt <= '0;
            end else if (!w_abort) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_abort          = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_GW'(NREQ - 1);
            r_busy       <= 1'b0;
            r_tx_data    <= 8'h00;
            r_last       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick_any && tx_ready) begin
                        r_grant <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_grant_valid) begin
                        r_tx_data <= req_data[{r_grant, 3'b000} +: 8];
                        r_last    <= req_last[r_grant];
                        r_state   <= c_START;
                    end else if (w_abort) begin
                        r_last_grant <= r_grant;
                        r_busy       <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                end
                c_START: begin
                    r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (tx_ready) begin
                        if (r_last) begin
                            r_last_grant <= r_grant;
                            r_busy       <= 1'b0;
                            r_state      <= c_IDLE;
                        end else begin
                            r_state <= c_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == c_SEND) begin
            w_req_ready[r_grant] = 1'b1;
        end
    end

    assign req_ready = w_req_ready;
    assign tx_start  = (r_state == c_START);
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb with requester queues,
//               a serializer model and a packet-level round-robin scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int NREQ  = 4;
    localparam int DEPTH = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [1:0]        grant;
    logic              busy;
    logic              err_timeout;

    uart_tx_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   sent_total = 0;
    int   err_seen = 0;
    int   err_at = -1;
    logic err_busy = 1'b1;
    int   stall_cnt = 0;
    int   ser_cnt = 0;
    int   fixed_hold = 0;

    // Requester byte streams: src_pos = accepted, exp_pos = seen on tx
    logic [7:0] mem [NREQ][DEPTH];
    logic       lst [NREQ][DEPTH];
    int         len     [NREQ];
    int         src_pos [NREQ];
    int         exp_pos [NREQ];
    int         sb_last;
    int         sb_owner;
    bit         sb_in_pkt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next();
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (sb_last + k) % NREQ;
            if (exp_pos[j] < len[j]) return j;
        end
        return -1;
    endfunction

    task automatic present_all();
        for (int i = 0; i < NREQ; i++) begin
            if (src_pos[i] < len[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = mem[i][src_pos[i]];
                req_last[i]         = lst[i][src_pos[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic l);
        mem[i][len[i]] = b;
        lst[i][len[i]] = l;
        len[i]++;
    endtask

    task automatic tick();
        logic            st;
        logic [7:0]      d;
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] rdy;
        int              g;
        int              o;
        st  = tx_start;
        d   = tx_data;
        rdy = req_ready;
        acc = req_valid & req_ready;
        g   = int'(grant);
        if (sb_in_pkt) check("ready_owner", 32'(rdy & ~(4'(1) << sb_owner)), 32'd0);
        if ((rdy & ~req_valid) != '0) stall_cnt++;
        @(posedge clk);
        #1;
        if (err_timeout === 1'b1) begin
            err_seen++;
            err_at    = stall_cnt;
            err_busy  = busy;
            sb_in_pkt = 1'b0;
            sb_last   = sb_owner;
        end
        if (st) begin
            if (!sb_in_pkt) begin
                o = rr_next();
                check("rr_grant", g, o);
            end else begin
                o = sb_owner;
                check("pkt_owner", g, o);
            end
            if (o < 0 || exp_pos[o] >= len[o]) begin
                check("extra_byte", g, 32'hffffffff);
            end else begin
                check("tx_data", d, mem[o][exp_pos[o]]);
                sb_in_pkt = !lst[o][exp_pos[o]];
                exp_pos[o]++;
                sb_owner = o;
                if (!sb_in_pkt) sb_last = o;
            end
            sent_total++;
            ser_cnt  = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 6));
            tx_ready = 1'b0;
        end else if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) tx_ready = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) src_pos[i]++;
        end
        present_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_in_pkt = 1'b0;
        sb_last   = NREQ - 1;
        for (int i = 0; i < NREQ; i++) len[i] = src_pos[i];
        present_all();
    endtask

    task automatic run_until_sent(input int n, input int budget);
        int b;
        b = budget;
        while (sent_total < n && b > 0) begin
            tick();
            b--;
        end
        check("sent_count", sent_total, n);
    endtask

    task automatic run_until_idle();
        int b;
        b = 300;
        while ((busy !== 1'b0 || tx_ready !== 1'b1) && b > 0) begin
            tick();
            b--;
        end
        check("idle_wait", {busy, tx_ready}, 32'd1);
    endtask

    initial begin
        int s;
        int total;
        rst       = 1'b1;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        sb_in_pkt = 1'b0;
        sb_last   = NREQ - 1;
        sb_owner  = 0;
        for (int i = 0; i < NREQ; i++) begin
            len[i] = 0; src_pos[i] = 0; exp_pos[i] = 0;
        end

        // Reset values
        tick();
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_tx_start", tx_start, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_grant", grant, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_err", err_timeout, 32'd0);
        do_reset();

        // Single requester, 3-byte packet, 10-cycle serializer
        fixed_hold = 10;
        s = sent_total;
        load(0, 8'h41, 1'b0);
        load(0, 8'h42, 1'b0);
        load(0, 8'h43, 1'b1);
        present_all();
        tick();
        check("accept_latency", req_ready, 32'd1);
        check("busy_set", busy, 32'd1);
        tick();
        check("start_pulse", tx_start, 32'd1);
        check("first_byte", tx_data, 32'h41);
        run_until_sent(s + 3, 200);
        begin
            int b;
            b = 50;
            while (tx_ready !== 1'b1 && b > 0) begin tick(); b--; end
        end
        check("busy_in_drain", busy, 32'd1);
        tick();
        check("busy_end", busy, 32'd0);
        check("grant_end", grant, 32'd0);

        // Requesters 0 and 2 collide, 2-byte packets each
        fixed_hold = 3;
        run_until_idle();
        do_reset();
        s = sent_total;
        load(0, 8'hA0, 1'b0); load(0, 8'hA1, 1'b1);
        load(2, 8'hC0, 1'b0); load(2, 8'hC1, 1'b1);
        present_all();
        run_until_sent(s + 4, 300);

        // Saturated random packets from all requesters
        fixed_hold = 0;
        run_until_idle();
        s = sent_total;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            int npk;
            npk = int'($urandom_range(2, 3));
            for (int p = 0; p < npk; p++) begin
                int pl;
                pl = int'($urandom_range(1, 3));
                for (int k = 0; k < pl; k++) begin
                    load(i, 8'($urandom), (k == pl - 1));
                    total++;
                end
            end
        end
        present_all();
        run_until_sent(s + total, 3000);

        // Reset in DRAIN mid-packet
        fixed_hold = 4;
        run_until_idle();
        do_reset();
        s = sent_total;
        load(1, 8'h55, 1'b1);
        present_all();
        run_until_sent(s + 1, 100);
        run_until_idle();
        s = sent_total;
        load(2, 8'h61, 1'b0); load(2, 8'h62, 1'b0); load(2, 8'h63, 1'b1);
        present_all();
        run_until_sent(s + 1, 100);
        check("in_drain_busy", busy, 32'd1);
        do_reset();
        check("midrst_busy", busy, 32'd0);
        check("midrst_tx_start", tx_start, 32'd0);
        check("midrst_req_ready", req_ready, 32'd0);
        s = sent_total;
        load(3, 8'h73, 1'b1);
        load(1, 8'h71, 1'b1);
        present_all();
        run_until_sent(s + 2, 200);

        // Requester 1 stalls mid-packet with requester 2 pending
        run_until_idle();
        do_reset();
        stall_cnt = 0;
        s = sent_total;
        load(1, 8'h10, 1'b0);
        load(2, 8'h20, 1'b1);
        present_all();
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int b;
            b = 300;
            while (err_seen == 0 && b > 0) begin tick(); b--; end
        end
        check("err_seen", err_seen, 32'd1);
        check("timeout_cycles", err_at, 32'd50);
        check("busy_abort", err_busy, 32'd0);
        tick();
        check("err_pulse_width", err_timeout, 32'd0);
        run_until_sent(s + 2, 100);
        check("grant_after_abort", grant, 32'd2);
        check("err_once", err_seen, 32'd1);
`else
        repeat (80) tick();
        check("stall_grant", grant, 32'd1);
        check("stall_busy", busy, 32'd1);
        check("stall_ready", req_ready, 32'd2);
        check("stall_sent", sent_total, s + 1);
        check("err_never", err_seen, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
